// File: rtl/modulo_entrada.sv
// Input-side companion to the IN path: debounces the pushbutton, queues switch
// bytes on each press and hands them to the control unit through a le/pronto handshake.
module modulo_entrada #(
    parameter int DEBOUNCE = 16,
    parameter int DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     chave,
    input  logic [7:0]               dadosIN,
    input  logic                     le,
    output logic [31:0]              dadoSaida,
    output logic                     pronto,
    output logic                     vazio,
    output logic                     cheio,
    output logic [$clog2(DEPTH):0]   contagem,
    output logic                     perdido
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int DBW = $clog2(DEBOUNCE);
    localparam logic [CW-1:0]  FULLCOUNT = CW'(DEPTH);
    localparam logic [DBW-1:0] DBMAX     = DBW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {OCIOSO, ESPERA, ENTREGA, LIBERA} estado_t;

    logic           chaveS1, chaveS2;
    logic [7:0]     dadosS1, dadosS2;
    logic           nivelAceito;
    logic [DBW-1:0] contDeb;
    logic           captura;

    logic [7:0]     mem [DEPTH];
    logic [PW-1:0]  wrPtr, rdPtr;
    logic [CW-1:0]  nextCount;
    logic           wrEn, pop;

    estado_t        estado, proxEstado;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chaveS1 <= 1'b1;
            chaveS2 <= 1'b1;
            dadosS1 <= '0;
            dadosS2 <= '0;
        end else begin
            chaveS1 <= chave;
            chaveS2 <= chaveS1;
            dadosS1 <= dadosIN;
            dadosS2 <= dadosS1;
        end
    end

    // The accepted level only moves after DEBOUNCE consecutive differing cycles;
    // only the press direction (1->0) raises captura for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nivelAceito <= 1'b1;
            contDeb     <= '0;
            captura     <= 1'b0;
        end else begin
            captura <= 1'b0;
            if (chaveS2 == nivelAceito) begin
                contDeb <= '0;
            end else if (contDeb == DBMAX) begin
                contDeb     <= '0;
                nivelAceito <= chaveS2;
                captura     <= nivelAceito & ~chaveS2;
            end else begin
                contDeb <= contDeb + 1'b1;
            end
        end
    end

    // A pop in the same cycle frees a slot, so a capture into a full FIFO still lands.
    assign wrEn = captura & (~cheio | pop);

    always_comb begin
        nextCount = contagem;
        if (wrEn && !pop) begin
            nextCount = contagem + 1'b1;
        end else if (!wrEn && pop) begin
            nextCount = contagem - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrPtr] <= dadosS2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            contagem  <= '0;
            vazio     <= 1'b1;
            cheio     <= 1'b0;
            perdido   <= 1'b0;
            dadoSaida <= '0;
        end else begin
            if (wrEn) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr     <= rdPtr + 1'b1;
                dadoSaida <= {24'd0, mem[rdPtr]};
            end
            if (captura && !wrEn) begin
                perdido <= 1'b1;
            end
            contagem <= nextCount;
            vazio    <= (nextCount == '0);
            cheio    <= (nextCount == FULLCOUNT);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= OCIOSO;
        end else begin
            estado <= proxEstado;
        end
    end

    always_comb begin
        proxEstado = estado;
        case (estado)
            OCIOSO:  if (le) proxEstado = vazio ? ESPERA : ENTREGA;
            ESPERA:  if (!le) proxEstado = OCIOSO;
                     else if (!vazio) proxEstado = ENTREGA;
            ENTREGA: proxEstado = le ? LIBERA : OCIOSO;
            LIBERA:  if (!le) proxEstado = OCIOSO;
            default: proxEstado = OCIOSO;
        endcase
    end

    // Pop decisions use the registered vazio, so a same-cycle capture is never bypassed.
    always_comb begin
        pronto = (estado == ENTREGA);
        pop    = 1'b0;
        if ((estado == OCIOSO || estado == ESPERA) && le && !vazio) begin
            pop = 1'b1;
        end
    end

endmodule

// File: doc/modulo_entrada.md
# modulo_entrada

Input-side companion to the processor's IN path. Synchronises and debounces the `chave` pushbutton and, on each press, captures the 8-bit `dadosIN` switch value into a small FIFO. It delivers queued bytes zero-extended to 32 bits through a level request / one-cycle ready handshake driven by the processor's control unit during an input instruction. This decouples operator key presses from instruction timing: presses made before the IN executes are queued, and an IN issued with nothing queued stalls until a press arrives.

## Interface
Parameters:
- `DEBOUNCE`, default 16: consecutive stable cycles required to accept a new button level; legal range ≥ 2.
- `DEPTH`, default 4: number of FIFO entries; must be a power of 2, ≥ 2.

Ports:
- `clk` in 1: single clock, the divided processor clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `chave` in 1: raw pushbutton, active-low (0 = pressed), asynchronous to `clk`.
- `dadosIN` in 8: raw switch bank, asynchronous to `clk`.
- `le` in 1: read request from control; held high until `pronto` is seen.
- `dadoSaida` out 32: delivered word, `{24'd0, byte}`; held between reads.
- `pronto` out 1: one-cycle pulse; `dadoSaida` is valid in that cycle and afterwards.
- `vazio` out 1: FIFO empty.
- `cheio` out 1: FIFO full.
- `contagem` out $clog2(DEPTH)+1: number of FIFO entries, 0..DEPTH.
- `perdido` out 1: sticky flag; set when a press is dropped because the FIFO is full.

## Operation
- **Synchroniser:** `chave` and `dadosIN` each pass through two flops.
- **Debounce:**
  - A counter runs while the synchronised `chave` differs from the accepted level.
  - When the difference has persisted for `DEBOUNCE` consecutive cycles, the accepted level is updated.
  - Any cycle where the synchronised `chave` equals the accepted level clears the counter.
- **Capture:** a transition of the accepted level 1→0 produces a one-cycle `captura` pulse.
  - Holding the button produces exactly one capture.
  - Release (0→1) is debounced in the same way but produces no capture.
- **FIFO write:** on `captura`, the synchronised `dadosIN` is written at the write pointer.
  - If the FIFO is full with no pop in the same cycle, the byte is dropped and `perdido` is set until `rst`.
  - Pointers wrap modulo `DEPTH`.
- **Read FSM:**
  - `OCIOSO`: if `le`=1 and not empty, pop the head into `dadoSaida` and go to `ENTREGA`. If `le`=1 and empty, go to `ESPERA`.
  - `ESPERA`: when not empty, pop the head into `dadoSaida` and go to `ENTREGA`.
  - `ENTREGA`: `pronto`=1. Go to `LIBERA` if `le`=1, otherwise go to `OCIOSO`.
  - `LIBERA`: wait for `le`=0, then go to `OCIOSO`. Exactly one pop occurs per `le` high period.
- **No bypass:** a pop sees only entries present at the start of the cycle. A capture into an empty FIFO is readable from the next cycle.
- **Simultaneous capture and pop:**
  - Both take effect and `contagem` is unchanged.
  - When full, the write is accepted because the pop frees a slot, and `perdido` is not set.
- **Flags:** `vazio`, `cheio` and `contagem` are registered and reflect the post-edge FIFO state.

## Timing
- **Reset values:**
  - Outputs: `dadoSaida`=0, `pronto`=0, `vazio`=1, `cheio`=0, `contagem`=0, `perdido`=0.
  - Internal: FSM in `OCIOSO`, accepted button level = 1 (released), debounce counter = 0.
- **Press latency:** `chave` falls and stays low; the entry is visible (`contagem` increments) 2 + `DEBOUNCE` + 1 cycles later. A shorter glitch is never captured.
- **Read latency, data available:** `le` is sampled high in `OCIOSO` at edge N, and `pronto`=1 in the cycle after edge N.
- **Read latency, empty:** `pronto` asserts one cycle after the edge at which `vazio` is sampled 0 in `ESPERA`.
- **`pronto`:** never high for more than one cycle per request.
- **Reset mid-operation:** asserting `rst` in `ESPERA`, `ENTREGA` or `LIBERA` returns to `OCIOSO` and empties the FIFO. If `le` is still high after reset, it is treated as a new request.
- **`le` dropped in `ESPERA`:** the request is abandoned, the FSM returns to `OCIOSO`, and nothing is popped.

## Test plan
- **Single press (`DEBOUNCE`=4):** reset, `dadosIN`=8'hA5, `chave` low for 20 cycles then high → `contagem`=1 exactly 7 cycles after the fall. Then `le`=1 → `pronto` pulses once, `dadoSaida`=32'h000000A5, `vazio`=1.
- **Bounce rejection:** `chave` toggles every 2 cycles for 30 cycles, then stays low → exactly one capture; `contagem`=1.
- **Order, wrap-around and overflow (`DEPTH`=4):**
  - Press 5 times with values 1, 2, 3, 4, 5 → `cheio`=1, `perdido`=1, `contagem`=4.
  - Four reads return 1, 2, 3, 4. Two more presses (6, 7) then reads return 6, 7, so the pointers wrap.
- **Stall:** FIFO empty, `le`=1 held → FSM in `ESPERA`, no `pronto` for 50 cycles. Press with 8'h3C → `pronto` and `dadoSaida`=32'h3C. FSM holds `LIBERA` until `le`=0, with no second pop.
- **Simultaneous capture and pop while full:** `captura` and pop occur in the same cycle → `contagem` stays 4, `perdido` stays 0, and the new byte is read last.
- **Reset mid-read:** `rst` pulsed while in `ESPERA` with `le`=1 → all outputs return to their reset values. With 2 entries queued before the reset, `contagem`=0 afterwards.
